// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point definitions for the neural-network activation units.
// Provides the Q8.8 word format, the value 1.0 and a rounding-constant helper
// used wherever a wide product is shifted back down to Q8.8.
package nn_fixed_pkg;

    localparam int unsigned Q_W    = 16;
    localparam int unsigned Q_FRAC = 8;

    localparam logic [Q_W-1:0] Q_ONE = 16'h0100;

    // Signed Q8.8 word, shared with the forward sigmoid and other activations.
    typedef logic signed [Q_W-1:0] q8_8_t;

    // Half an LSB of the result when discarding 'shift' fractional bits.
    // Adding this before an arithmetic right shift gives round-half-up.
    function automatic logic [63:0] round_half(input int unsigned shift);
        if (shift == 0) begin
            return 64'd0;
        end
        return 64'd1 << (shift - 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// Valid/ready register slice with per-stage valid and stall propagation.
// The slice loads whenever it is empty or its content leaves this cycle,
// so in_ready depends only on the slice state and the downstream ready.
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   in_valid   upstream has data
//   in_ready   this slice accepts data this cycle
//   in_data    upstream data
//   out_valid  slice holds valid data
//   out_ready  downstream accepts the slice content
//   out_data   registered data (held while stalled)
module pipe_stage
    import nn_fixed_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          valid_q;
    logic [DW-1:0] data_q;

    assign in_ready  = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/sigmoid_backprop.sv
// Backward pass of the sigmoid activation: dx = dy * y * (1 - y), signed fixed
// point (Q8.8 at the defaults). Three-stage valid/ready pipeline:
//   S1 clamps y to [0, 1.0] and registers yc, om = 1.0 - yc and dy,
//   S2 registers p = yc * om (unsigned, 2*FRAC fractional bits) and dy,
//   S3 registers dx = round_half_up(dy * p >> 2*FRAC).
// A pair presented in cycle c (in_valid & in_ready) shows on dx in cycle c+3.
// Since p <= 0.25, |dx| <= |dy|/4 and no output saturation is required.
//
// Ports:
//   clk, rst             clock and asynchronous active-high reset
//   in_valid, in_ready   input handshake for the (y, dy) pair
//   y                    forward sigmoid output, legal range 0..1.0
//   dy                   upstream gradient
//   out_valid, out_ready output handshake for dx
//   dx                   input gradient
//   clamp_cnt            saturating count of accepted out-of-range y values
//   clr_cnt              synchronous clear of clamp_cnt (wins over increment)
module sigmoid_backprop
    import nn_fixed_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned FRAC  = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     y,
    input  logic [W-1:0]     dy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     dx,
    output logic [CNT_W-1:0] clamp_cnt,
    input  logic             clr_cnt
);

    localparam int unsigned YC_W   = FRAC + 1;          // 0..1.0 inclusive
    localparam int unsigned P_W    = 2 * FRAC + 1;      // Q0.(2*FRAC) product
    localparam int unsigned PROD_W = W + P_W;           // signed dy * p
    localparam int unsigned SH     = 2 * FRAC;
    localparam int unsigned S1_W   = 2 * YC_W + W;
    localparam int unsigned S2_W   = P_W + W;

    localparam logic [W-1:0]      ONE_W  = W'(1) << FRAC;
    localparam logic [YC_W-1:0]   ONE_YC = YC_W'(1) << FRAC;
    localparam logic [PROD_W-1:0] RND    = PROD_W'(round_half(SH));

    // ---------------------------------------------------------------- S1 ---
    logic            y_neg;
    logic            y_over;
    logic            clamp_hit;
    logic [YC_W-1:0] yc;
    logic [YC_W-1:0] om;
    logic [S1_W-1:0] s1_in;

    always_comb begin
        y_neg     = y[W-1];
        y_over    = ~y[W-1] & (y > ONE_W);
        clamp_hit = y_neg | y_over;
        yc        = y[YC_W-1:0];
        if (y_neg) begin
            yc = '0;
        end else if (y_over) begin
            yc = ONE_YC;
        end
        om    = ONE_YC - yc;
        s1_in = {yc, om, dy};
    end

    logic            v1;
    logic            r2;
    logic [S1_W-1:0] s1_q;

    pipe_stage #(
        .DW(S1_W)
    ) u_s1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (s1_in),
        .out_valid(v1),
        .out_ready(r2),
        .out_data (s1_q)
    );

    // ---------------------------------------------------------------- S2 ---
    logic [YC_W-1:0] yc1;
    logic [YC_W-1:0] om1;
    logic [W-1:0]    dy1;
    logic [P_W-1:0]  p;
    logic [S2_W-1:0] s2_in;

    always_comb begin
        yc1   = s1_q[S1_W-1 -: YC_W];
        om1   = s1_q[W +: YC_W];
        dy1   = s1_q[W-1:0];
        p     = P_W'(yc1) * P_W'(om1);
        s2_in = {p, dy1};
    end

    logic            v2;
    logic            r3;
    logic [S2_W-1:0] s2_q;

    pipe_stage #(
        .DW(S2_W)
    ) u_s2 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (v1),
        .in_ready (r2),
        .in_data  (s2_in),
        .out_valid(v2),
        .out_ready(r3),
        .out_data (s2_q)
    );

    // ---------------------------------------------------------------- S3 ---
    logic [P_W-1:0]           p2;
    logic [W-1:0]             dy2;
    logic signed [PROD_W-1:0] dy_ext;
    logic signed [PROD_W-1:0] p_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] rounded;
    logic [W-1:0]             dx_next;

    always_comb begin
        p2      = s2_q[S2_W-1 -: P_W];
        dy2     = s2_q[W-1:0];
        dy_ext  = PROD_W'($signed(dy2));      // sign-extend
        p_ext   = $signed(PROD_W'(p2));       // zero-extend, p is unsigned
        prod    = dy_ext * p_ext;
        rounded = prod + $signed(RND);
        dx_next = W'(rounded >>> SH);
    end

    pipe_stage #(
        .DW(W)
    ) u_s3 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (v2),
        .in_ready (r3),
        .in_data  (dx_next),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (dx)
    );

    // ------------------------------------------------------ clamp counter ---
    logic accept;

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clamp_cnt <= '0;
        end else if (clr_cnt) begin
            clamp_cnt <= '0;
        end else if (accept && clamp_hit && (clamp_cnt != {CNT_W{1'b1}})) begin
            clamp_cnt <= clamp_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sigmoid_backprop.sv
module tb_sigmoid_backprop;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] y;
    logic [15:0] dy;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dx;
    logic [15:0] clamp_cnt;
    logic        clr_cnt;

    sigmoid_backprop dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y        (y),
        .dy       (dy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dx       (dx),
        .clamp_cnt(clamp_cnt),
        .clr_cnt  (clr_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] dx;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   ready_mode = 1;  // 0 low, 1 high, 2 random
    int   exp_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Independent model: clamp, exact product, floor((prod + 2^15) / 2^16).
    function automatic logic [15:0] model(input logic [15:0] yv, input logic [15:0] dv);
        int     yi;
        int     yc;
        longint p;
        longint prod;
        longint num;
        longint q;
        yi = int'($signed(yv));
        yc = (yi < 0) ? 0 : (yi > 256) ? 256 : yi;
        p = longint'(yc * (256 - yc));
        prod = longint'($signed(dv)) * p;
        num = prod + 32768;
        q = num / 65536;
        if (num < 0 && (num % 65536) != 0) q = q - 1;
        return q[15:0];
    endfunction

    // out_ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
            else out_ready = (ready_mode == 1);
        end
    end

    // Monitor / scoreboard
    initial begin
        logic [15:0] held;
        bit          stalled;
        exp_t        e;
        stalled = 0;
        held = '0;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                stalled = 0;
            end else begin
                if (stalled) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_dx", 32'(dx), 32'(held));
                end
                stalled = out_valid && !out_ready;
                held = dx;
                if (out_valid && out_ready) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output: got dx=%h with empty scoreboard", dx);
                    end else begin
                        e = sbq.pop_front();
                        chk("dx", 32'(dx), 32'(e.dx));
                        if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd3);
                    end
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [15:0] yy, input logic [15:0] dd,
                        input logic [15:0] ee, input bit lat);
        int n;
        n = 0;
        in_valid = 1'b1;
        y = yy;
        dy = dd;
        #1;
        while (!in_ready) begin
            @(negedge clk);
            #1;
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout: in_ready stuck at 0 for y=%h", yy);
                in_valid = 1'b0;
                return;
            end
        end
        sbq.push_back('{dx: ee, acc: cyc, lat: lat});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [15:0] ry;
        logic [15:0] rdy;
        rst = 1'b1;
        in_valid = 1'b0;
        y = '0;
        dy = '0;
        clr_cnt = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dx", 32'(dx), 32'd0);
        chk("rst_clamp_cnt", 32'(clamp_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Directed vectors, isolated so latency is measurable
        send(16'h0080, 16'h0100, 16'h0040, 1);
        repeat (4) @(negedge clk);
        send(16'h0040, 16'hFF00, 16'hFFD0, 1);
        repeat (4) @(negedge clk);
        send(16'h00C0, 16'h0100, 16'h0030, 0);
        send(16'h0001, 16'h0080, 16'h0000, 0);
        send(16'h0080, 16'h8000, 16'hE000, 0);
        send(16'h0080, 16'hFFFE, 16'h0000, 0);  // exact -0.5 LSB rounds up to 0
        send(16'h0080, 16'h0002, 16'h0001, 0);  // exact +0.5 LSB rounds up to 1
        chk("cnt_no_clamp", 32'(clamp_cnt), 32'd0);
        send(16'hFFF0, 16'h0100, 16'h0000, 0);
        chk("cnt_neg_clamp", 32'(clamp_cnt), 32'd1);
        send(16'h0180, 16'h0200, 16'h0000, 0);
        chk("cnt_over_clamp", 32'(clamp_cnt), 32'd2);
        send(16'h0100, 16'h7FFF, 16'h0000, 0);
        chk("cnt_one_no_clamp", 32'(clamp_cnt), 32'd2);

        // Clear wins over a simultaneous clamped accept
        clr_cnt = 1'b1;
        send(16'hFFF0, 16'h0010, 16'h0000, 0);
        clr_cnt = 1'b0;
        chk("cnt_clr_priority", 32'(clamp_cnt), 32'd0);
        drain();

        // Random stream under pseudo-random backpressure
        exp_cnt = 0;
        ready_mode = 2;
        for (int i = 0; i < 10; i++) begin
            ry = 16'($urandom_range(0, 16'h01C0)) - 16'h0040;
            rdy = 16'($urandom);
            if ($signed(ry) < 0 || $signed(ry) > 16'sh0100) exp_cnt++;
            send(ry, rdy, model(ry, rdy), 0);
        end
        ready_mode = 1;
        drain();
        chk("cnt_random", 32'(clamp_cnt), 32'(exp_cnt));

        // Saturation
        for (int i = 0; i < 65536; i++) send(16'hFFF0, 16'h0100, 16'h0000, 0);
        drain();
        chk("cnt_saturate", 32'(clamp_cnt), 32'hFFFF);
        send(16'h0180, 16'h0100, 16'h0000, 0);
        chk("cnt_saturate_hold", 32'(clamp_cnt), 32'hFFFF);
        drain();

        // Reset with three results in flight
        ready_mode = 0;
        out_ready = 1'b0;
        send(16'h0080, 16'h0100, 16'h0040, 0);
        send(16'h0040, 16'h0100, 16'h0030, 0);
        send(16'h00C0, 16'h0200, 16'h0060, 0);
        #1;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        #1;
        rst = 1'b1;
        sbq.delete();
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_clamp_cnt", 32'(clamp_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ready_mode = 1;
        out_ready = 1'b1;
        #1;
        chk("postrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        send(16'h0040, 16'hFF00, 16'hFFD0, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
